// File: rtl/result_packer_if.sv
// Bus bundle for result_packer: PE lane beat inputs on one side and the
// output-buffer line write port on the other.
interface result_packer_if #(
    parameter int ADDR_W = 13
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       valid;
    logic [ADDR_W-1:0] addr_1, addr_2, addr_3, addr_4, addr_5, addr_6, addr_7, addr_8;
    logic [ADDR_W-1:0] addr_9, addr_10, addr_11, addr_12, addr_13, addr_14, addr_15, addr_16;
    logic [7:0]        data_1, data_2, data_3, data_4, data_5, data_6, data_7, data_8;
    logic [7:0]        data_9, data_10, data_11, data_12, data_13, data_14, data_15, data_16;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] addr_out;
    logic [127:0]      data_out;
    logic [15:0]       byte_en;
    logic              busy;

    // Producer side: the PE array and the output-buffer write port.
    modport master (
        output in_valid, valid, flush, out_ready,
        output addr_1, addr_2, addr_3, addr_4, addr_5, addr_6, addr_7, addr_8,
        output addr_9, addr_10, addr_11, addr_12, addr_13, addr_14, addr_15, addr_16,
        output data_1, data_2, data_3, data_4, data_5, data_6, data_7, data_8,
        output data_9, data_10, data_11, data_12, data_13, data_14, data_15, data_16,
        input  in_ready, out_valid, addr_out, data_out, byte_en, busy
    );

    // Packer side.
    modport slave (
        input  in_valid, valid, flush, out_ready,
        input  addr_1, addr_2, addr_3, addr_4, addr_5, addr_6, addr_7, addr_8,
        input  addr_9, addr_10, addr_11, addr_12, addr_13, addr_14, addr_15, addr_16,
        input  data_1, data_2, data_3, data_4, data_5, data_6, data_7, data_8,
        input  data_9, data_10, data_11, data_12, data_13, data_14, data_15, data_16,
        output in_ready, out_valid, addr_out, data_out, byte_en, busy
    );
endinterface

// File: rtl/result_packer.sv
// Packs 16 per-lane result bytes into 16-byte-aligned lines with byte enables.
// Optional idle auto-flush of a partial line: define PACKER_TIMEOUT_EN.
module result_packer #(
    parameter int ADDR_W = 13
`ifdef PACKER_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic           clk,
    input  logic           rst,
    result_packer_if.slave bus
);
    localparam int TAG_W = ADDR_W - 4;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] OPEN  = 2'd1;
    localparam logic [1:0] MERGE = 2'd2;
    localparam logic [1:0] EMIT  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr [16];
    logic [7:0]        r_data [16];
    logic [15:0]       r_pend;
    logic [TAG_W-1:0]  r_lineTag;
    logic [127:0]      r_lineData;
    logic [15:0]       r_byteEn;

    logic [ADDR_W-1:0] w_laneAddr [16];
    logic [7:0]        w_laneData [16];
    logic              w_inReady;
    logic              w_accept;
    logic              w_timeout;
    logic [TAG_W-1:0]  w_tag;
    logic              w_found;
    logic [127:0]      w_mergeData;
    logic [15:0]       w_mergeEn;
    logic [15:0]       w_mergePend;

    assign w_laneAddr[0]  = bus.addr_1;   assign w_laneData[0]  = bus.data_1;
    assign w_laneAddr[1]  = bus.addr_2;   assign w_laneData[1]  = bus.data_2;
    assign w_laneAddr[2]  = bus.addr_3;   assign w_laneData[2]  = bus.data_3;
    assign w_laneAddr[3]  = bus.addr_4;   assign w_laneData[3]  = bus.data_4;
    assign w_laneAddr[4]  = bus.addr_5;   assign w_laneData[4]  = bus.data_5;
    assign w_laneAddr[5]  = bus.addr_6;   assign w_laneData[5]  = bus.data_6;
    assign w_laneAddr[6]  = bus.addr_7;   assign w_laneData[6]  = bus.data_7;
    assign w_laneAddr[7]  = bus.addr_8;   assign w_laneData[7]  = bus.data_8;
    assign w_laneAddr[8]  = bus.addr_9;   assign w_laneData[8]  = bus.data_9;
    assign w_laneAddr[9]  = bus.addr_10;  assign w_laneData[9]  = bus.data_10;
    assign w_laneAddr[10] = bus.addr_11;  assign w_laneData[10] = bus.data_11;
    assign w_laneAddr[11] = bus.addr_12;  assign w_laneData[11] = bus.data_12;
    assign w_laneAddr[12] = bus.addr_13;  assign w_laneData[12] = bus.data_13;
    assign w_laneAddr[13] = bus.addr_14;  assign w_laneData[13] = bus.data_14;
    assign w_laneAddr[14] = bus.addr_15;  assign w_laneData[14] = bus.data_15;
    assign w_laneAddr[15] = bus.addr_16;  assign w_laneData[15] = bus.data_16;

    assign w_inReady = ((r_state == EMPTY) || (r_state == OPEN)) && !bus.flush;
    assign w_accept  = bus.in_valid && w_inReady;

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_state == EMIT);
    assign bus.busy      = (r_state != EMPTY);
    assign bus.addr_out  = {r_lineTag, 4'b0000};
    assign bus.data_out  = r_lineData;
    assign bus.byte_en   = r_byteEn;

`ifdef PACKER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_idleCnt;

    assign w_timeout = (r_state == OPEN) && (r_idleCnt == CNT_W'(TIMEOUT - 1));

    // Counts idle cycles in OPEN; any beat, flush or leaving OPEN restarts it.
    always_ff @(posedge clk) begin
        if (rst || (r_state != OPEN) || w_accept || bus.flush || w_timeout) begin
            r_idleCnt <= '0;
        end else begin
            r_idleCnt <= r_idleCnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // One merge step: an open line keeps its tag, otherwise the lowest pending
    // lane picks it. Later lanes overwrite earlier ones on byte collisions.
    always_comb begin
        w_tag       = r_lineTag;
        w_found     = 1'b0;
        w_mergeData = r_lineData;
        w_mergeEn   = r_byteEn;
        w_mergePend = r_pend;
        if (r_byteEn == 16'h0000) begin
            for (int i = 0; i < 16; i++) begin
                if (r_pend[i] && !w_found) begin
                    w_tag   = r_addr[i][ADDR_W-1:4];
                    w_found = 1'b1;
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (r_pend[i] && (r_addr[i][ADDR_W-1:4] == w_tag)) begin
                w_mergeData[{r_addr[i][3:0], 3'b000} +: 8] = r_data[i];
                w_mergeEn[r_addr[i][3:0]]                  = 1'b1;
                w_mergePend[i]                             = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < 16; i++) begin
                r_addr[i] <= w_laneAddr[i];
                r_data[i] <= w_laneData[i];
            end
        end
    end

    // Line assembly state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_pend     <= '0;
            r_lineTag  <= '0;
            r_lineData <= '0;
            r_byteEn   <= '0;
        end else begin
            case (r_state)
                EMPTY, OPEN: begin
                    if (w_accept) begin
                        r_pend <= bus.valid;
                        if (bus.valid != 16'h0000) begin
                            r_state <= MERGE;
                        end
                    end else if ((r_state == OPEN) && (bus.flush || w_timeout)) begin
                        r_state <= EMIT;
                    end
                end
                MERGE: begin
                    r_lineTag  <= w_tag;
                    r_lineData <= w_mergeData;
                    r_byteEn   <= w_mergeEn;
                    r_pend     <= w_mergePend;
                    if ((w_mergePend != 16'h0000) || (w_mergeEn == 16'hFFFF)) begin
                        r_state <= EMIT;
                    end else begin
                        r_state <= OPEN;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        r_lineTag  <= '0;
                        r_lineData <= '0;
                        r_byteEn   <= '0;
                        r_state    <= (r_pend != 16'h0000) ? MERGE : EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_packer.sv
// Directed self-checking bench for result_packer; timeout checks run only
// when PACKER_TIMEOUT_EN is defined.
module tb_result_packer;
    logic clk;
    logic rst;

    logic [12:0] laneAddr [16];
    logic [7:0]  laneData [16];

    int totalChecks;
    int badChecks;

    result_packer_if bus ();

    result_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.addr_1  = laneAddr[0];   assign bus.data_1  = laneData[0];
    assign bus.addr_2  = laneAddr[1];   assign bus.data_2  = laneData[1];
    assign bus.addr_3  = laneAddr[2];   assign bus.data_3  = laneData[2];
    assign bus.addr_4  = laneAddr[3];   assign bus.data_4  = laneData[3];
    assign bus.addr_5  = laneAddr[4];   assign bus.data_5  = laneData[4];
    assign bus.addr_6  = laneAddr[5];   assign bus.data_6  = laneData[5];
    assign bus.addr_7  = laneAddr[6];   assign bus.data_7  = laneData[6];
    assign bus.addr_8  = laneAddr[7];   assign bus.data_8  = laneData[7];
    assign bus.addr_9  = laneAddr[8];   assign bus.data_9  = laneData[8];
    assign bus.addr_10 = laneAddr[9];   assign bus.data_10 = laneData[9];
    assign bus.addr_11 = laneAddr[10];  assign bus.data_11 = laneData[10];
    assign bus.addr_12 = laneAddr[11];  assign bus.data_12 = laneData[11];
    assign bus.addr_13 = laneAddr[12];  assign bus.data_13 = laneData[12];
    assign bus.addr_14 = laneAddr[13];  assign bus.data_14 = laneData[13];
    assign bus.addr_15 = laneAddr[14];  assign bus.data_15 = laneData[14];
    assign bus.addr_16 = laneAddr[15];  assign bus.data_16 = laneData[15];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // Presents one beat for a single cycle; returns in the cycle after the accept edge.
    task automatic applyStimulus(input logic [15:0] mask);
        bus.valid    = mask;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.valid    = 16'h0000;
    endtask

    task automatic drainWord();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    logic [12:0]  splitAddr [16];
    logic [127:0] expData;

    initial begin
        totalChecks   = 0;
        badChecks     = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.valid     = 16'h0000;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            laneAddr[i] = '0;
            laneData[i] = '0;
        end
        splitAddr = '{13'h000, 13'h001, 13'h002, 13'h003, 13'h004, 13'h007, 13'h008, 13'h009,
                      13'h00A, 13'h00B, 13'h00E, 13'h00F, 13'h010, 13'h011, 13'h012, 13'h015};

        tick();
        tick();
        checkOutput("rstOutValid", bus.out_valid, 1'b0);
        checkOutput("rstAddrOut",  bus.addr_out, 13'h000);
        checkOutput("rstDataOut",  bus.data_out, 128'h0);
        checkOutput("rstByteEn",   bus.byte_en, 16'h0000);
        checkOutput("rstBusy",     bus.busy, 1'b0);
        checkOutput("rstInReady",  bus.in_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Full line at 0x020 with backpressure.
        for (int i = 0; i < 16; i++) begin
            laneAddr[i] = 13'(32'h020 + i);
            laneData[i] = 8'(i + 1);
        end
        applyStimulus(16'hFFFF);
        checkOutput("fullMergeValid", bus.out_valid, 1'b0);
        checkOutput("fullMergeReady", bus.in_ready, 1'b0);
        checkOutput("fullMergeBusy",  bus.busy, 1'b1);
        tick();
        expData = 128'h100F0E0D_0C0B0A09_08070605_04030201;
        checkOutput("fullValid", bus.out_valid, 1'b1);
        checkOutput("fullAddr",  bus.addr_out, 13'h020);
        checkOutput("fullEn",    bus.byte_en, 16'hFFFF);
        checkOutput("fullData",  bus.data_out, expData);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bpValid", bus.out_valid, 1'b1);
            checkOutput("bpAddr",  bus.addr_out, 13'h020);
            checkOutput("bpEn",    bus.byte_en, 16'hFFFF);
            checkOutput("bpData",  bus.data_out, expData);
            checkOutput("bpReady", bus.in_ready, 1'b0);
        end
        drainWord();
        checkOutput("fullDoneValid", bus.out_valid, 1'b0);
        checkOutput("fullDoneBusy",  bus.busy, 1'b0);
        checkOutput("fullDoneEn",    bus.byte_en, 16'h0000);

        // Beat spanning lines 0x000 and 0x010.
        for (int i = 0; i < 16; i++) begin
            laneAddr[i] = splitAddr[i];
            laneData[i] = 8'(i + 1);
        end
        applyStimulus(16'hFFFF);
        tick();
        checkOutput("split0Valid", bus.out_valid, 1'b1);
        checkOutput("split0Addr",  bus.addr_out, 13'h000);
        checkOutput("split0En",    bus.byte_en, 16'hCF9F);
        checkOutput("split0Data",  bus.data_out, 128'h0C0B0000_0A090807_06000005_04030201);
        drainWord();
        checkOutput("split1MergeValid", bus.out_valid, 1'b0);
        checkOutput("split1MergeBusy",  bus.busy, 1'b1);
        tick();
        checkOutput("split1OpenReady", bus.in_ready, 1'b1);
        checkOutput("split1OpenEn",    bus.byte_en, 16'h0027);
        tick();
        checkOutput("split1StaysOpen", bus.out_valid, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("split1Valid", bus.out_valid, 1'b1);
        checkOutput("split1Addr",  bus.addr_out, 13'h010);
        checkOutput("split1En",    bus.byte_en, 16'h0027);
        checkOutput("split1Data",  bus.data_out, 128'h00000000_00000000_00001000_000F0E0D);
        drainWord();
        checkOutput("split1DoneBusy", bus.busy, 1'b0);

        // Flush in EMPTY does nothing; an all-invalid beat is dropped.
        bus.flush = 1'b1;
        #1;
        checkOutput("flushEmptyReady", bus.in_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        checkOutput("flushEmptyValid", bus.out_valid, 1'b0);
        checkOutput("flushEmptyBusy",  bus.busy, 1'b0);
        applyStimulus(16'h0000);
        checkOutput("dropBusy", bus.busy, 1'b0);

        // Two beats merging into one line at 0x040.
        for (int i = 0; i < 16; i++) begin
            laneAddr[i] = 13'(32'h040 + i);
            laneData[i] = 8'(32'h31 + i);
        end
        applyStimulus(16'h00FF);
        tick();
        checkOutput("crossAValid", bus.out_valid, 1'b0);
        checkOutput("crossAEn",    bus.byte_en, 16'h00FF);
        checkOutput("crossAReady", bus.in_ready, 1'b1);
        applyStimulus(16'hFF00);
        tick();
        checkOutput("crossValid", bus.out_valid, 1'b1);
        checkOutput("crossAddr",  bus.addr_out, 13'h040);
        checkOutput("crossEn",    bus.byte_en, 16'hFFFF);
        checkOutput("crossData",  bus.data_out, 128'h403F3E3D_3C3B3A39_38373635_34333231);
        drainWord();
        checkOutput("crossDoneBusy", bus.busy, 1'b0);

        // Two lanes hitting the same byte: higher lane wins.
        laneAddr[0] = 13'h105;  laneData[0] = 8'hAA;
        laneAddr[1] = 13'h105;  laneData[1] = 8'hBB;
        applyStimulus(16'h0003);
        tick();
        checkOutput("collOpen", bus.out_valid, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("collValid", bus.out_valid, 1'b1);
        checkOutput("collAddr",  bus.addr_out, 13'h100);
        checkOutput("collEn",    bus.byte_en, 16'h0020);
        checkOutput("collData",  bus.data_out, 128'h00000000_00000000_0000BB00_00000000);
        drainWord();

        // Reset while a word is being presented.
        for (int i = 0; i < 16; i++) begin
            laneAddr[i] = 13'(32'h020 + i);
            laneData[i] = 8'(i + 1);
        end
        applyStimulus(16'hFFFF);
        tick();
        checkOutput("rstEmitValid", bus.out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstMidValid", bus.out_valid, 1'b0);
        checkOutput("rstMidBusy",  bus.busy, 1'b0);
        checkOutput("rstMidEn",    bus.byte_en, 16'h0000);
        checkOutput("rstMidData",  bus.data_out, 128'h0);
        checkOutput("rstMidReady", bus.in_ready, 1'b1);

`ifdef PACKER_TIMEOUT_EN
        begin
            int idleCycles;
            laneAddr[0] = 13'h0A3;
            laneData[0] = 8'h5C;
            applyStimulus(16'h0001);
            tick();
            idleCycles = 0;
            while (!bus.out_valid && idleCycles < 200) begin
                tick();
                idleCycles++;
            end
            checkOutput("toCycles", 128'(idleCycles), 128'd64);
            checkOutput("toAddr",   bus.addr_out, 13'h0A0);
            checkOutput("toEn",     bus.byte_en, 16'h0008);
            drainWord();
        end
`endif

        tick();
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
